// File: rtl/checkout_pkg.sv
// Shared definitions for the checkout sequencer: label layout, validity codes and FSM states.
package checkout_pkg;

    localparam int LABEL_W   = 12;
    localparam int CODE_W    = 3;
    localparam int MONTH_W   = 4;
    localparam int DAY_W     = 5;
    localparam int CODE_LSB  = 0;
    localparam int MONTH_LSB = CODE_LSB + CODE_W;
    localparam int DAY_LSB   = MONTH_LSB + MONTH_W;
    localparam int P_W       = 4;
    localparam int V_W       = 2;

    typedef enum logic [V_W-1:0] {
        V_OK      = 2'b00,
        V_TODAY   = 2'b01,
        V_EXPIRED = 2'b10,
        V_UNKNOWN = 2'b11
    } validity_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        ACCUM = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic logic [CODE_W-1:0] label_code(input logic [LABEL_W-1:0] label);
        return label[CODE_LSB +: CODE_W];
    endfunction

endpackage

// File: rtl/checkout_sequencer_if.sv
// Scanner-lane, datapath and sale-summary signals of the checkout sequencer.
interface checkout_sequencer_if #(
    parameter int N_REQ   = 2,
    parameter int TOTAL_W = 12,
    parameter int CNT_W   = 8
);
    import checkout_pkg::*;

    logic [N_REQ-1:0]         req_valid;
    logic [LABEL_W*N_REQ-1:0] req_label;
    logic [N_REQ-1:0]         req_ready;
    logic                     close;
    logic [LABEL_W-1:0]       L;
    logic                     en;
    logic [P_W-1:0]           P;
    logic [V_W-1:0]           V;
    logic [TOTAL_W-1:0]       total;
    logic [CNT_W-1:0]         n_items;
    logic [CNT_W-1:0]         n_expired;
    logic                     overflow;
    logic                     busy;
    logic                     sale_done;

    // The sequencer itself.
    modport slave (
        input  req_valid, req_label, close, P, V,
        output req_ready, L, en, total, n_items, n_expired, overflow, busy, sale_done
    );

    // Scanners, datapath and the sale reporter around it.
    modport master (
        output req_valid, req_label, close, P, V,
        input  req_ready, L, en, total, n_items, n_expired, overflow, busy, sale_done
    );
endinterface

// File: rtl/checkout_sequencer_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer, pointer moves past the winner on advance.
module rr_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] grant
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] winner;

    always_comb begin
        int  idx;
        logic found;
        grant  = '0;
        winner = ptr;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = PTR_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            ptr <= '0;
        end else if (advance && (|grant)) begin
            ptr <= (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

endmodule

// File: rtl/checkout_sequencer.sv
// Checkout sequencer: arbitrates scanner lanes, drives the product-check datapath, keeps the sale summary.
// Optional CHECKOUT_REJECT_EXPIRED_EN: expired items are only counted in n_expired.
module checkout_sequencer
    import checkout_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int LAT     = 2,
    parameter int TOTAL_W = 12,
    parameter int CNT_W   = 8
) (
    input logic                  clk,
    input logic                  clr,
    checkout_sequencer_if.slave  bus
);
    localparam int LAT_CW    = (LAT > 2) ? $clog2(LAT) : 1;
    localparam int WAIT_LOAD = (LAT > 1) ? LAT - 2 : 0;

    state_t               state, state_nx;
    logic [LAT_CW-1:0]    lat_cnt;
    logic [LABEL_W-1:0]   l_hold;
    logic [LABEL_W-1:0]   sel_label;
    logic [N_REQ-1:0]     grant;
    logic [N_REQ-1:0]     ready;
    logic                 issue_en;
    logic                 close_pend;
    logic [TOTAL_W-1:0]   total;
    logic [CNT_W-1:0]     n_items;
    logic [CNT_W-1:0]     n_expired;
    logic                 overflow;
    logic [TOTAL_W:0]     total_sum;
    logic                 is_expired;
    logic                 add_item;

    function automatic logic [TOTAL_W-1:0] sat_total(input logic [TOTAL_W:0] sum);
        return sum[TOTAL_W] ? '1 : sum[TOTAL_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk     (clk),
        .clr     (clr),
        .req     (bus.req_valid),
        .advance (state == ISSUE),
        .grant   (grant)
    );

    always_comb begin
        sel_label = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) sel_label = bus.req_label[LABEL_W*i +: LABEL_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) state <= IDLE;
        else      state <= state_nx;
    end

    // A close seen in IDLE wins over a request arriving in the same cycle.
    always_comb begin
        state_nx = state;
        ready    = '0;
        issue_en = 1'b0;
        case (state)
            IDLE: begin
                if (close_pend || bus.close)  state_nx = DONE;
                else if (|bus.req_valid)      state_nx = ISSUE;
            end
            ISSUE: begin
                ready    = grant;
                issue_en = |grant;
                if (!(|grant))      state_nx = IDLE;
                else if (LAT == 1)  state_nx = ACCUM;
                else                state_nx = WAIT;
            end
            WAIT: begin
                if (lat_cnt == '0) state_nx = ACCUM;
            end
            ACCUM:   state_nx = IDLE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign total_sum  = {1'b0, total} + {{(TOTAL_W + 1 - P_W){1'b0}}, bus.P};
    assign is_expired = (validity_t'(bus.V) == V_EXPIRED);
`ifdef CHECKOUT_REJECT_EXPIRED_EN
    assign add_item   = !is_expired;
`else
    assign add_item   = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!clr) begin
            l_hold     <= '0;
            lat_cnt    <= '0;
            total      <= '0;
            n_items    <= '0;
            n_expired  <= '0;
            overflow   <= 1'b0;
            close_pend <= 1'b0;
        end else begin
            if (state == DONE) close_pend <= bus.close;
            else if (bus.close) close_pend <= 1'b1;

            case (state)
                ISSUE: begin
                    l_hold  <= sel_label;
                    lat_cnt <= LAT_CW'(WAIT_LOAD);
                end
                WAIT: begin
                    if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
                end
                // P and V are valid exactly LAT cycles after the issue cycle.
                ACCUM: begin
                    if (add_item) begin
                        total   <= sat_total(total_sum);
                        n_items <= sat_inc(n_items);
                    end
                    if (is_expired) n_expired <= sat_inc(n_expired);
                    if ((add_item && (total_sum[TOTAL_W] || (&n_items))) ||
                        (is_expired && (&n_expired)))
                        overflow <= 1'b1;
                end
                DONE: begin
                    total     <= '0;
                    n_items   <= '0;
                    n_expired <= '0;
                    overflow  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = ready;
    assign bus.en        = issue_en;
    assign bus.L         = (state == ISSUE) ? sel_label : l_hold;
    assign bus.total     = total;
    assign bus.n_items   = n_items;
    assign bus.n_expired = n_expired;
    assign bus.overflow  = overflow;
    assign bus.busy      = (state != IDLE);
    assign bus.sale_done = (state == DONE);

endmodule

// File: tb/tb_checkout_sequencer.sv
// Directed bench for checkout_sequencer with a LAT=2 product-check datapath model (reference date 25/02).
module tb_checkout_sequencer;
    import checkout_pkg::*;

    localparam int N_REQ   = 2;
    localparam int LAT     = 2;
    localparam int TOTAL_W = 12;
    localparam int CNT_W   = 8;

    localparam logic [11:0] LBL_A    = 12'b111111100010; // 31/12 code 2, price 10
    localparam logic [11:0] LBL_HUEV = 12'b110010010101; // 25/02 code 5, price 15, today
    localparam logic [11:0] LBL_ATUN = 12'b110100010001; // 26/02 code 1, price 4
    localparam logic [11:0] LBL_EXP  = 12'b101000010001; // 20/02 code 1, price 4, expired
    localparam logic [11:0] LBL_BIG  = 12'b111111100101; // 31/12 code 5, price 15

`ifdef CHECKOUT_REJECT_EXPIRED_EN
    localparam int EXP_TOTAL = 19;
    localparam int EXP_ITEMS = 2;
`else
    localparam int EXP_TOTAL = 23;
    localparam int EXP_ITEMS = 3;
`endif

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    checkout_sequencer_if #(.N_REQ(N_REQ), .TOTAL_W(TOTAL_W), .CNT_W(CNT_W)) bus ();

    checkout_sequencer #(.N_REQ(N_REQ), .LAT(LAT), .TOTAL_W(TOTAL_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    // Datapath model: label registered on en, result one stage later.
    logic [11:0] s1 = '0;
    logic [11:0] s2 = '0;

    function automatic logic [3:0] price(input logic [11:0] l);
        case (l[2:0])
            3'd0: return 4'd3;
            3'd1: return 4'd4;
            3'd2: return 4'd10;
            3'd3: return 4'd6;
            3'd4: return 4'd8;
            3'd5: return 4'd15;
            3'd6: return 4'd2;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [1:0] validity(input logic [11:0] l);
        logic [8:0] date;
        date = {l[6:3], l[11:7]};
        if (l[2:0] == 3'd7)            return 2'b11;
        if (date < {4'd2, 5'd25})      return 2'b10;
        if (date == {4'd2, 5'd25})     return 2'b01;
        return 2'b00;
    endfunction

    always @(posedge clk) begin
        if (bus.en) s1 <= bus.L;
        s2 <= s1;
    end

    assign bus.P = price(s2);
    assign bus.V = validity(s2);

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int lane, input logic [11:0] lbl, input logic v);
        bus.req_label[12*lane +: 12] = lbl;
        bus.req_valid[lane]          = v;
    endtask

    task automatic wait_issue(input int lane);
        int k;
        k = 0;
        while (bus.req_ready[lane] !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        check($sformatf("grant_lane%0d", lane), 32'(bus.req_ready[lane]), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = '0;
        bus.req_label = '0;
        bus.close     = 1'b0;

        // Reset state
        clr = 1'b0;
        step(2);
        check("rst_total", 32'(bus.total), 0);
        check("rst_items", 32'(bus.n_items), 0);
        check("rst_expired", 32'(bus.n_expired), 0);
        check("rst_overflow", 32'(bus.overflow), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_sale_done", 32'(bus.sale_done), 0);
        check("rst_en", 32'(bus.en), 0);
        check("rst_L", 32'(bus.L), 0);
        check("rst_ready", 32'(bus.req_ready), 0);
        clr = 1'b1;
        step(2);
        check("idle_busy", 32'(bus.busy), 0);
        check("idle_ready", 32'(bus.req_ready), 0);

        // Single item on lane 0
        set_lane(0, LBL_A, 1'b1);
        wait_issue(0);
        check("single_en", 32'(bus.en), 1);
        check("single_L", 32'(bus.L), 32'(LBL_A));
        check("single_ready", 32'(bus.req_ready), 32'b01);
        step();
        set_lane(0, LBL_A, 1'b0);
        check("single_en_off", 32'(bus.en), 0);
        check("single_L_hold", 32'(bus.L), 32'(LBL_A));
        step(3);
        check("single_total", 32'(bus.total), 10);
        check("single_items", 32'(bus.n_items), 1);
        check("single_expired", 32'(bus.n_expired), 0);
        check("single_busy", 32'(bus.busy), 0);

        // Fresh sale with pointer back at 0, both lanes contending
        clr = 1'b0;
        step();
        clr = 1'b1;
        check("clr_total", 32'(bus.total), 0);
        set_lane(0, LBL_HUEV, 1'b1);
        set_lane(1, LBL_ATUN, 1'b1);
        wait_issue(0);
        check("cont_grant0", 32'(bus.req_ready), 32'b01);
        step();
        set_lane(0, LBL_HUEV, 1'b0);
        wait_issue(1);
        check("cont_grant1", 32'(bus.req_ready), 32'b10);
        check("cont_L1", 32'(bus.L), 32'(LBL_ATUN));
        step();
        set_lane(1, LBL_ATUN, 1'b0);
        step(3);
        check("cont_total", 32'(bus.total), 19);
        check("cont_items", 32'(bus.n_items), 2);
        check("cont_expired", 32'(bus.n_expired), 0);

        // Expired item
        set_lane(0, LBL_EXP, 1'b1);
        wait_issue(0);
        step();
        set_lane(0, LBL_EXP, 1'b0);
        step(3);
        check("exp_total", 32'(bus.total), EXP_TOTAL);
        check("exp_items", 32'(bus.n_items), EXP_ITEMS);
        check("exp_expired", 32'(bus.n_expired), 1);

        // Close during WAIT: the in-flight item completes first
        set_lane(1, LBL_ATUN, 1'b1);
        wait_issue(1);
        step();
        set_lane(1, LBL_ATUN, 1'b0);
        bus.close = 1'b1;
        step();
        bus.close = 1'b0;
        step(2);
        check("close_done", 32'(bus.sale_done), 1);
        check("close_busy", 32'(bus.busy), 1);
        check("close_total", 32'(bus.total), EXP_TOTAL + 4);
        check("close_items", 32'(bus.n_items), EXP_ITEMS + 1);
        check("close_expired", 32'(bus.n_expired), 1);
        step();
        check("close_done_off", 32'(bus.sale_done), 0);
        check("close_clr_total", 32'(bus.total), 0);
        check("close_clr_items", 32'(bus.n_items), 0);
        check("close_clr_expired", 32'(bus.n_expired), 0);

        // Close and request in the same IDLE cycle: close wins
        bus.close = 1'b1;
        set_lane(0, LBL_BIG, 1'b1);
        step();
        bus.close = 1'b0;
        check("race_done", 32'(bus.sale_done), 1);
        check("race_ready", 32'(bus.req_ready), 0);
        step(2);
        check("race_grant", 32'(bus.req_ready), 32'b01);

        // Saturation: ~300 items of price 15 exceed both total and item counter
        step(1200);
        set_lane(0, LBL_BIG, 1'b0);
        step(6);
        check("sat_total", 32'(bus.total), 4095);
        check("sat_items", 32'(bus.n_items), 255);
        check("sat_overflow", 32'(bus.overflow), 1);
        bus.close = 1'b1;
        step();
        bus.close = 1'b0;
        begin
            int k;
            k = 0;
            while (bus.sale_done !== 1'b1 && k < 10) begin
                step();
                k++;
            end
        end
        check("sat_done", 32'(bus.sale_done), 1);
        check("sat_done_ovf", 32'(bus.overflow), 1);
        step();
        check("sat_clr_total", 32'(bus.total), 0);
        check("sat_clr_ovf", 32'(bus.overflow), 0);

        // Reset during WAIT drops the in-flight item
        set_lane(0, LBL_A, 1'b1);
        wait_issue(0);
        step();
        check("mid_busy", 32'(bus.busy), 1);
        clr = 1'b0;
        step();
        clr = 1'b1;
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_ready", 32'(bus.req_ready), 0);
        check("mid_rst_en", 32'(bus.en), 0);
        check("mid_rst_L", 32'(bus.L), 0);
        step();
        check("mid_regrant", 32'(bus.req_ready), 32'b01);
        step();
        set_lane(0, LBL_A, 1'b0);
        step(3);
        check("mid_total", 32'(bus.total), 10);
        check("mid_items", 32'(bus.n_items), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
